wb_arbiter2: RTL and testbench

- Two-master to one-slave Wishbone classic arbiter.
- Lets the CPU core (master 0) and a second requester (master 1, debug/DMA loader) share the single memory/peripheral slave bus.
- Round-robin grant, held for a full cyc cycle.
- Bus-timeout watchdog returns err to a master whose slave never answers.

---
 rtl/wb_arbiter2.sv | 178 +++++++++++++++++
 tb/tb_wb_arbiter2.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone classic arbiter, round-robin, grant held for a whole cyc.
// Latency: one cycle of arbitration in IDLE; once granted, all paths are combinational pass-through.
// Backpressure: the non-owner sees no termination (stalled); owner is throttled only by the slave or the watchdog.
module wb_arbiter2 #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // master 0 (CPU core)
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  // master 1 (debug / DMA loader)
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  // shared slave
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  // one-hot current owner, 00 while idle
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  // Watchdog fires when the counter has already seen TIMEOUT_CYCLES-1 silent strobe cycles.
  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_owner;
  logic             w_last_owner_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             w_g0;
  logic             w_g1;
  logic             w_granted;
  logic             w_own_cyc;
  logic             w_own_stb;
  logic             w_own_we;
  logic [31:0]      w_own_adr;
  logic [3:0]       w_own_sel;
  logic [31:0]      w_own_dat;
  logic             w_term;
  logic             w_timeout;

  assign w_g0      = (r_state == GRANT0);
  assign w_g1      = (r_state == GRANT1);
  assign w_granted = w_g0 | w_g1;
  assign w_term    = s_ack_i | s_err_i | s_rty_i;

  // Select the current owner's request signals; all zero while idle so nothing leaks to the slave.
  always_comb begin
    w_own_cyc = 1'b0;
    w_own_stb = 1'b0;
    w_own_we  = 1'b0;
    w_own_adr = '0;
    w_own_sel = '0;
    w_own_dat = '0;
    case (r_state)
      GRANT0: begin
        w_own_cyc = m0_cyc_i;
        w_own_stb = m0_stb_i;
        w_own_we  = m0_we_i;
        w_own_adr = m0_adr_i;
        w_own_sel = m0_sel_i;
        w_own_dat = m0_dat_i;
      end
      GRANT1: begin
        w_own_cyc = m1_cyc_i;
        w_own_stb = m1_stb_i;
        w_own_we  = m1_we_i;
        w_own_adr = m1_adr_i;
        w_own_sel = m1_sel_i;
        w_own_dat = m1_dat_i;
      end
      default: ;
    endcase
  end

  // A real slave termination in the same cycle always beats the watchdog.
  assign w_timeout = TO_EN && w_granted && w_own_cyc && w_own_stb && !w_term && (r_cnt == TO_LAST);

  // Next-state, last-owner and watchdog counter: arbitrate in IDLE, hold grant until owner drops cyc.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_owner_nxt = r_last_owner;
    w_cnt_nxt        = '0;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          // last_owner resets to 1, so master 0 wins the first contested arbitration
          w_state_nxt = r_last_owner ? GRANT0 : GRANT1;
        end else if (m0_cyc_i) begin
          w_state_nxt = GRANT0;
        end else if (m1_cyc_i) begin
          w_state_nxt = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (!w_own_cyc) begin
          // no direct handover: always pass through IDLE so the other master gets a fair look
          w_state_nxt      = IDLE;
          w_last_owner_nxt = (r_state == GRANT1);
        end else if (TO_EN && w_own_stb && !w_term && !w_timeout) begin
          w_cnt_nxt = r_cnt + CNT_W'(1'b1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, last-owner and watchdog registers; async reset clears any in-flight transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  // Slave side: owner's request, strobe withdrawn on the watchdog cycle.
  assign s_cyc_o = w_own_cyc;
  assign s_stb_o = w_own_cyc & w_own_stb & ~w_timeout;
  assign s_we_o  = w_own_we;
  assign s_adr_o = w_own_adr;
  assign s_sel_o = w_own_sel;
  assign s_dat_o = w_own_dat;

  // Master side: only the owner sees read data and terminations; watchdog err is OR-ed in.
  assign m0_dat_o = w_g0 ? s_dat_i : '0;
  assign m0_ack_o = w_g0 & s_ack_i;
  assign m0_err_o = w_g0 & (s_err_i | w_timeout);
  assign m0_rty_o = w_g0 & s_rty_i;

  assign m1_dat_o = w_g1 ? s_dat_i : '0;
  assign m1_ack_o = w_g1 & s_ack_i;
  assign m1_err_o = w_g1 & (s_err_i | w_timeout);
  assign m1_rty_o = w_g1 & s_rty_i;

  assign grant_o = {w_g1, w_g0};

endmodule

// File: tb/tb_wb_arbiter2.sv
module tb_wb_arbiter2;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cyc, stb, we;
  logic [31:0] adr [2];
  logic [31:0] dat [2];
  logic [3:0]  sel [2];
  logic [31:0] s_dat;
  logic        s_ack, s_err, s_rty;

  wire [31:0] mdo [2];
  wire [1:0]  mack, merr, mrty;
  wire        s_cyc, s_stb, s_we;
  wire [31:0] s_adr, s_dout;
  wire [3:0]  s_sel;
  wire [1:0]  grant;

  wire [31:0] zmdo [2];
  wire [1:0]  zack, zerr, zrty;
  wire        z_s_cyc, z_s_stb, z_s_we;
  wire [31:0] z_s_adr, z_s_dout;
  wire [3:0]  z_s_sel;
  wire [1:0]  z_grant;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]),
    .m0_sel_i(sel[0]), .m0_dat_i(dat[0]), .m0_dat_o(mdo[0]),
    .m0_ack_o(mack[0]), .m0_err_o(merr[0]), .m0_rty_o(mrty[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]),
    .m1_sel_i(sel[1]), .m1_dat_i(dat[1]), .m1_dat_o(mdo[1]),
    .m1_ack_o(mack[1]), .m1_err_o(merr[1]), .m1_rty_o(mrty[1]),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_sel_o(s_sel), .s_dat_o(s_dout), .s_dat_i(s_dat),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .grant_o(grant)
  );

  // Same stimulus, watchdog disabled.
  wb_arbiter2 #(.TIMEOUT_CYCLES(0), .CNT_W(8)) u_dut_noto (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]),
    .m0_sel_i(sel[0]), .m0_dat_i(dat[0]), .m0_dat_o(zmdo[0]),
    .m0_ack_o(zack[0]), .m0_err_o(zerr[0]), .m0_rty_o(zrty[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]),
    .m1_sel_i(sel[1]), .m1_dat_i(dat[1]), .m1_dat_o(zmdo[1]),
    .m1_ack_o(zack[1]), .m1_err_o(zerr[1]), .m1_rty_o(zrty[1]),
    .s_cyc_o(z_s_cyc), .s_stb_o(z_s_stb), .s_we_o(z_s_we), .s_adr_o(z_s_adr),
    .s_sel_o(z_s_sel), .s_dat_o(z_s_dout), .s_dat_i(s_dat),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .grant_o(z_grant)
  );

  task automatic idle_inputs();
    cyc = '0; stb = '0; we = '0;
    for (int k = 0; k < 2; k++) begin
      adr[k] = '0; dat[k] = '0; sel[k] = '0;
    end
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves the bench at a falling edge with reset released: that cycle is "cycle 0".
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    cyc = 2'b11; stb = 2'b11; adr[0] = 32'h55; s_ack = 1'b1; s_err = 1'b1; s_rty = 1'b1;
    s_dat = 32'hFFFF_FFFF;
    #1;
    n_chk++;
    if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b expected 00", grant); end
    n_chk++;
    if ({s_cyc, s_stb, s_we, s_adr} !== 35'd0) begin
      n_fail++; $display("FAIL reset_slave: got cyc=%b stb=%b adr=%h expected zeros", s_cyc, s_stb, s_adr);
    end
    n_chk++;
    if ({mack, merr, mrty, mdo[0], mdo[1]} !== 70'd0) begin
      n_fail++; $display("FAIL reset_master: got ack=%b err=%b rty=%b expected zeros", mack, merr, mrty);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h100; sel[0] = 4'hF;
    #1;
    n_chk++;
    if ({grant, s_cyc} !== 3'b000) begin
      n_fail++; $display("FAIL read_cycle0: got grant=%b s_cyc=%b expected 00/0", grant, s_cyc);
    end
    tick();
    s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
    #1;
    n_chk++;
    if ({grant, s_stb, s_adr} !== {2'b01, 1'b1, 32'h100}) begin
      n_fail++; $display("FAIL read_fwd: got grant=%b stb=%b adr=%h expected 01/1/100", grant, s_stb, s_adr);
    end
    n_chk++;
    if ({mdo[0], mack[0], mack[1], mdo[1]} !== {32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL read_return: got dat0=%h ack=%b%b dat1=%h expected deadbeef ack0=1 ack1=0",
                         mdo[0], mack[0], mack[1], mdo[1]);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_both_first();
    do_reset();
    cyc = 2'b11; stb = 2'b11; adr[0] = 32'hA0; adr[1] = 32'hB0;
    tick();
    #1;
    n_chk++;
    if ({grant, s_adr} !== {2'b01, 32'hA0}) begin
      n_fail++; $display("FAIL both_first: got grant=%b adr=%h expected 01/a0", grant, s_adr);
    end
    tick();
    cyc[0] = 1'b0;
    #1;
    n_chk++;
    if ({grant, s_cyc, s_stb} !== {2'b01, 2'b00}) begin
      n_fail++; $display("FAIL both_release: got grant=%b cyc=%b stb=%b expected 01/0/0", grant, s_cyc, s_stb);
    end
    tick();
    #1;
    n_chk++;
    if ({grant, s_cyc} !== 3'b000) begin
      n_fail++; $display("FAIL both_idle_gap: got grant=%b s_cyc=%b expected 00/0", grant, s_cyc);
    end
    tick();
    #1;
    n_chk++;
    if ({grant, s_adr} !== {2'b10, 32'hB0}) begin
      n_fail++; $display("FAIL both_second: got grant=%b adr=%h expected 10/b0", grant, s_adr);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [1:0] g, prev_g, last_rec;
    int nrec;
    do_reset();
    cyc = 2'b11; stb = 2'b11; s_ack = 1'b1;
    prev_g = 2'b00; last_rec = 2'b00; nrec = 0;
    for (int c = 0; c < 24; c++) begin
      g = grant;
      for (int k = 0; k < 2; k++) begin
        if (!cyc[k]) cyc[k] = 1'b1;
        else if (g[k] && prev_g[k]) cyc[k] = 1'b0;
      end
      if (g != 2'b00 && prev_g == 2'b00) begin
        n_chk++;
        if ((nrec == 0) ? (g !== 2'b01) : (g === last_rec)) begin
          n_fail++; $display("FAIL alternate_%0d: got grant=%b previous grant=%b", nrec, g, last_rec);
        end
        last_rec = g;
        nrec++;
      end
      prev_g = g;
      tick();
    end
    n_chk++;
    if (nrec !== 8) begin n_fail++; $display("FAIL alternate_count: got %0d grants expected 8", nrec); end
    idle_inputs();
  endtask

  task automatic test_m1_write();
    do_reset();
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h2000; sel[1] = 4'b0011; dat[1] = 32'h1234;
    s_ack = 1'b1;
    tick();
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h3000; sel[0] = 4'hF; dat[0] = 32'h5555;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_chk++;
      if ({grant, s_cyc, s_stb, s_we, s_adr, s_sel, s_dout} !== {2'b10, 3'b111, 32'h2000, 4'b0011, 32'h1234}) begin
        n_fail++; $display("FAIL m1_write_fwd: got grant=%b we=%b adr=%h sel=%b dat=%h", grant, s_we, s_adr, s_sel, s_dout);
      end
      n_chk++;
      if ({mack[0], mack[1]} !== 2'b01) begin
        n_fail++; $display("FAIL m1_write_ack: got ack0=%b ack1=%b expected 0/1", mack[0], mack[1]);
      end
      tick();
    end
    cyc[1] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_chk++;
      if ({mack[0], s_cyc} !== 2'b00) begin
        n_fail++; $display("FAIL m0_wait_%0d: got ack0=%b s_cyc=%b expected 0/0", c, mack[0], s_cyc);
      end
      tick();
    end
    #1;
    n_chk++;
    if ({grant, mack[0], s_adr} !== {2'b01, 1'b1, 32'h3000}) begin
      n_fail++; $display("FAIL m0_after_m1: got grant=%b ack0=%b adr=%h expected 01/1/3000", grant, mack[0], s_adr);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout();
    logic exp_err, exp_ack;
    do_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h40;
    tick();
    for (int k = 1; k <= 8; k++) begin
      s_ack = (k == 8);
      exp_err = (k == 4);
      exp_ack = (k == 8);
      #1;
      n_chk++;
      if ({merr[0], mack[0], s_stb} !== {exp_err, exp_ack, !exp_err}) begin
        n_fail++; $display("FAIL timeout_stb%0d: got err=%b ack=%b s_stb=%b expected %b/%b/%b",
                           k, merr[0], mack[0], s_stb, exp_err, exp_ack, !exp_err);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_no_timeout();
    int bad;
    do_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h44; sel[0] = 4'h5; dat[0] = 32'h77; s_dat = 32'hA5A5_A5A5;
    tick();
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      #1;
      if ({z_s_cyc, z_s_stb, z_s_we, z_s_adr, z_s_sel, z_s_dout, z_grant,
           zmdo[0], zack[0], zerr[0], zrty[0], zmdo[1], zack[1], zerr[1], zrty[1]} !==
          {3'b110, 32'h44, 4'h5, 32'h77, 2'b01, 32'hA5A5_A5A5, 3'b000, 32'h0, 3'b000}) bad++;
      tick();
    end
    n_chk++;
    if (bad !== 0) begin n_fail++; $display("FAIL no_timeout: got %0d deviating cycles expected 0", bad); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h80;
    tick();
    tick();
    s_ack = 1'b1;
    #1;
    n_chk++;
    if ({grant, s_cyc, s_stb} !== 4'b0111) begin
      n_fail++; $display("FAIL arst_pre: got grant=%b cyc=%b stb=%b expected 01/1/1", grant, s_cyc, s_stb);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({grant, s_cyc, s_stb, mack, merr} !== 8'd0) begin
      n_fail++; $display("FAIL arst_drop: got grant=%b cyc=%b stb=%b ack=%b err=%b expected zeros",
                         grant, s_cyc, s_stb, mack, merr);
    end
    cyc = 2'b10; stb = 2'b10; s_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #1;
    n_chk++;
    if (grant !== 2'b10) begin n_fail++; $display("FAIL arst_m1_alone: got grant=%b expected 10", grant); end
    #2 rst_n = 1'b0;
    cyc = 2'b11; stb = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #1;
    n_chk++;
    if (grant !== 2'b01) begin n_fail++; $display("FAIL arst_both: got grant=%b expected 01", grant); end
    tick();
    idle_inputs();
  endtask

  // Behavioural model: owner as an integer (-1 idle), round-robin by "whoever did not go last",
  // and a count of consecutive unanswered strobe cycles.
  task automatic test_random();
    int mo, ml, mw;
    logic term, to;
    logic [70:0] exp_s, act_s;
    logic [34:0] exp_m [2];
    logic [34:0] act_m [2];
    logic [1:0]  exp_g;
    do_reset();
    mo = -1; ml = 1; mw = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        cyc[k] = cyc[k] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
        stb[k] = ($urandom_range(0, 4) != 0);
        we[k]  = $urandom_range(0, 1) != 0;
        adr[k] = $urandom;
        sel[k] = 4'($urandom_range(0, 15));
        dat[k] = $urandom;
      end
      s_ack = ($urandom_range(0, 5) == 0);
      s_err = ($urandom_range(0, 15) == 0);
      s_rty = ($urandom_range(0, 15) == 0);
      s_dat = $urandom;
      #1;
      term = s_ack | s_err | s_rty;
      to = 1'b0;
      exp_s = '0; exp_m[0] = '0; exp_m[1] = '0; exp_g = 2'b00;
      if (mo >= 0) begin
        to = (mw == TO - 1) && cyc[mo] && stb[mo] && !term;
        exp_s = {cyc[mo], cyc[mo] & stb[mo] & !to, we[mo], adr[mo], sel[mo], dat[mo]};
        exp_m[mo] = {s_dat, s_ack, s_err | to, s_rty};
        exp_g = (mo == 0) ? 2'b01 : 2'b10;
      end
      act_s = {s_cyc, s_stb, s_we, s_adr, s_sel, s_dout};
      act_m[0] = {mdo[0], mack[0], merr[0], mrty[0]};
      act_m[1] = {mdo[1], mack[1], merr[1], mrty[1]};
      n_chk++;
      if (grant !== exp_g) begin n_fail++; $display("FAIL rnd_grant c%0d: got %b expected %b", c, grant, exp_g); end
      n_chk++;
      if (act_s !== exp_s) begin n_fail++; $display("FAIL rnd_slave c%0d: got %h expected %h", c, act_s, exp_s); end
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (act_m[k] !== exp_m[k]) begin
          n_fail++; $display("FAIL rnd_m%0d c%0d: got %h expected %h", k, c, act_m[k], exp_m[k]);
        end
      end
      @(posedge clk);
      if (mo < 0) begin
        if (cyc[0] && cyc[1]) mo = 1 - ml;
        else if (cyc[0])      mo = 0;
        else if (cyc[1])      mo = 1;
        mw = 0;
      end else if (!cyc[mo]) begin
        ml = mo; mo = -1; mw = 0;
      end else if (stb[mo] && !term && !to) begin
        mw++;
      end else begin
        mw = 0;
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_both_first();
    test_back_to_back();
    test_m1_write();
    test_timeout();
    test_no_timeout();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
